// File: rtl/disp_pkg.sv
// Shared encodings and round-robin search for the display source scheduler.
package disp_pkg;

    localparam int MAX_SRC = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHOW   = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;

    // Unused upper req bits are zero, so a mod-8 walk equals a mod-NUM_SRC walk.
    function automatic logic [2:0] next_req(
        input logic [MAX_SRC-1:0] req,
        input logic [2:0]         cur
    );
        logic [2:0] idx;
        logic [2:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = cur + 3'(k);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/disp_src_sched_dwell_timer.sv
// Dwell counter: clear/enable, terminal count at DWELL_CYCLES-1.
module dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000,
    localparam int CNT_W = $clog2(DWELL_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST);

endmodule

// File: rtl/disp_src_sched.sv
// Round-robin time-sharing of the 7-seg display between debug sources.
// DISP_SRC_TAG_EN: overlay the source index on display nibble 7.
module disp_src_sched
    import disp_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    localparam int SEL_W = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC*32-1:0] src_val,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic                  auto_en,
    input  logic                  step,
    input  logic                  hold,
    output logic [31:0]           disp_val,
    output logic [SEL_W-1:0]      disp_sel,
    output logic                  disp_vld
);

    logic [1:0]         st_q, st_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [31:0]        val_q, val_d;
    logic [31:0]        pick;
    logic [MAX_SRC-1:0] req8;
    logic [SEL_W-1:0]   nxt;
    logic               tmr_clr, tmr_en, tmr_tc;

    assign req8 = MAX_SRC'(src_req);
    assign nxt  = SEL_W'(next_req(req8, 3'(sel_q)));

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk  (clk),
        .reset(reset),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .tc   (tmr_tc)
    );

    always_comb begin
        st_d    = st_q;
        sel_d   = sel_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (|src_req) begin
                    st_d  = ST_SHOW;
                    sel_d = SEL_W'(next_req(req8, 3'd7));
                end
            end
            ST_SHOW: begin
                if (hold) begin
                    st_d = ST_FREEZE;
                end else if (~|src_req) begin
                    st_d    = ST_IDLE;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en  = auto_en;
                    tmr_clr = !auto_en;
                    // Any mix of triggers collapses into a single advance.
                    if (step || (auto_en && tmr_tc) || !src_req[sel_q]) begin
                        sel_d   = nxt;
                        tmr_clr = 1'b1;
                    end
                end
            end
            ST_FREEZE: begin
                if (!hold) begin
                    if (~|src_req) begin
                        st_d    = ST_IDLE;
                        tmr_clr = 1'b1;
                    end else begin
                        st_d = ST_SHOW;
                        if (!src_req[sel_q]) begin
                            sel_d   = nxt;
                            tmr_clr = 1'b1;
                        end
                    end
                end
            end
            default: begin
                st_d    = ST_IDLE;
                tmr_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        pick = src_val[{sel_d, 5'd0} +: 32];
`ifdef DISP_SRC_TAG_EN
        pick[31:28] = 4'(sel_d);
`endif
    end

    always_comb begin
        val_d = val_q;
        if (st_d == ST_SHOW) begin
            val_d = pick;
        end else if (st_d == ST_IDLE) begin
            val_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= ST_IDLE;
            sel_q <= '0;
            val_q <= '0;
        end else begin
            st_q  <= st_d;
            sel_q <= sel_d;
            val_q <= val_d;
        end
    end

    assign disp_val = val_q;
    assign disp_sel = sel_q;
    assign disp_vld = (st_q != ST_IDLE);

endmodule

// File: tb/tb_disp_src_sched.sv
// Directed table plus randomized run against a behavioural model.
module tb_disp_src_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] src_val;
    logic [3:0]   src_req;
    logic         auto_en;
    logic         step;
    logic         hold;
    logic [31:0]  disp_val;
    logic [1:0]   disp_sel;
    logic         disp_vld;

    logic [31:0]  sv [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb src_val = {sv[3], sv[2], sv[1], sv[0]};

    disp_src_sched #(
        .NUM_SRC(4),
        .DWELL_CYCLES(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .src_val (src_val),
        .src_req (src_req),
        .auto_en (auto_en),
        .step    (step),
        .hold    (hold),
        .disp_val(disp_val),
        .disp_sel(disp_sel),
        .disp_vld(disp_vld)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        aut;
        logic        stp;
        logic        hld;
        logic [31:0] sv3;
        int          rep;
        logic        e_vld;
        logic [1:0]  e_sel;
        logic [31:0] e_raw;
    } vec_t;

    function automatic logic [31:0] tagged_val(logic [31:0] v, int s);
`ifdef DISP_SRC_TAG_EN
        logic [31:0] r;
        r = v;
        r[31:28] = 4'(s);
        return r;
`else
        return v + 32'(s) * 0;
`endif
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 showing, 2 frozen.
    int          m_mode;
    int          m_sel;
    int          m_cnt;
    logic [31:0] m_val;

    function automatic int rr(logic [3:0] r, int s);
        for (int k = 1; k <= 4; k++) begin
            if (r[(s + k) % 4]) return (s + k) % 4;
        end
        return s;
    endfunction

    task automatic model_edge();
        bit trig;
        if (reset) begin
            m_mode = 0; m_sel = 0; m_cnt = 0; m_val = 0;
        end else if (m_mode == 0) begin
            m_cnt = 0;
            if (src_req != 0) begin
                m_mode = 1;
                m_sel  = rr(src_req, 3);
                m_val  = tagged_val(sv[m_sel], m_sel);
            end
        end else if (m_mode == 1) begin
            if (hold) begin
                m_mode = 2;
            end else if (src_req == 0) begin
                m_mode = 0; m_val = 0; m_cnt = 0;
            end else begin
                trig = step || (auto_en && m_cnt == 7) || !src_req[m_sel];
                if (trig) begin
                    m_sel = rr(src_req, m_sel);
                    m_cnt = 0;
                end else begin
                    m_cnt = auto_en ? m_cnt + 1 : 0;
                end
                m_val = tagged_val(sv[m_sel], m_sel);
            end
        end else begin
            if (!hold) begin
                if (src_req == 0) begin
                    m_mode = 0; m_val = 0; m_cnt = 0;
                end else begin
                    m_mode = 1;
                    if (!src_req[m_sel]) begin
                        m_sel = rr(src_req, m_sel);
                        m_cnt = 0;
                    end
                    m_val = tagged_val(sv[m_sel], m_sel);
                end
            end
        end
    endtask

    vec_t vt [$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic a, logic s,
                                logic h, logic [31:0] v3, int n,
                                logic ev, logic [1:0] es, logic [31:0] er);
        vec_t t;
        t.rst = r; t.req = q; t.aut = a; t.stp = s; t.hld = h;
        t.sv3 = v3; t.rep = n; t.e_vld = ev; t.e_sel = es; t.e_raw = er;
        return t;
    endfunction

    localparam logic [31:0] S0 = 32'hA0A0_0000;
    localparam logic [31:0] S1 = 32'h1234_5678;
    localparam logic [31:0] S3 = 32'h3333_3333;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] FF = 32'hFFFF_FFFF;

    initial begin
        vec_t t;
        logic [31:0] ev;
        sv[0] = S0; sv[1] = S1; sv[2] = 32'h2222_2222; sv[3] = S3;
        reset = 1'b1; src_req = '0; auto_en = 1'b0; step = 1'b0; hold = 1'b0;

        vt.push_back(mk(1, 4'b0000, 0, 0, 0, S3, 1, 0, 0, 0));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, S3, 5, 0, 0, 0));
        vt.push_back(mk(0, 4'b1010, 0, 0, 0, S3, 1, 1, 1, S1));
        vt.push_back(mk(0, 4'b1010, 0, 0, 0, S3, 20, 1, 1, S1));
        vt.push_back(mk(0, 4'b1010, 0, 1, 0, S3, 1, 1, 3, S3));
        vt.push_back(mk(0, 4'b0010, 0, 0, 0, S3, 1, 1, 1, S1));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, S3, 1, 0, 1, 0));
        vt.push_back(mk(0, 4'b0000, 0, 0, 1, S3, 2, 0, 1, 0));
        vt.push_back(mk(0, 4'b1111, 0, 0, 0, S3, 1, 1, 0, S0));
        vt.push_back(mk(0, 4'b1111, 1, 0, 0, S3, 7, 1, 0, S0));
        vt.push_back(mk(0, 4'b1111, 1, 0, 0, S3, 8, 1, 1, S1));
        vt.push_back(mk(0, 4'b1111, 1, 0, 0, S3, 8, 1, 2, 32'h2222_2222));
        vt.push_back(mk(0, 4'b1111, 1, 0, 0, S3, 8, 1, 3, S3));
        vt.push_back(mk(0, 4'b1111, 1, 0, 0, S3, 8, 1, 0, S0));
        vt.push_back(mk(0, 4'b1111, 0, 0, 0, S3, 1, 1, 0, S0));
        vt.push_back(mk(0, 4'b1111, 0, 1, 0, S3, 1, 1, 1, S1));
        vt.push_back(mk(0, 4'b1111, 0, 1, 0, S3, 1, 1, 2, 32'h2222_2222));
        vt.push_back(mk(0, 4'b1011, 0, 1, 0, S3, 1, 1, 3, S3));
        vt.push_back(mk(0, 4'b1011, 0, 0, 0, S3, 1, 1, 3, S3));
        vt.push_back(mk(0, 4'b1011, 0, 0, 1, S3, 1, 1, 3, S3));
        vt.push_back(mk(0, 4'b1011, 0, 1, 1, DB, 1, 1, 3, S3));
        vt.push_back(mk(0, 4'b1011, 0, 0, 1, DB, 3, 1, 3, S3));
        vt.push_back(mk(0, 4'b1011, 0, 0, 0, DB, 1, 1, 3, DB));
        vt.push_back(mk(0, 4'b1011, 0, 0, 0, FF, 1, 1, 3, FF));
        vt.push_back(mk(0, 4'b0011, 0, 0, 1, FF, 2, 1, 3, FF));
        vt.push_back(mk(0, 4'b0011, 0, 0, 0, FF, 1, 1, 0, S0));
        vt.push_back(mk(0, 4'b0011, 1, 0, 0, FF, 3, 1, 0, S0));
        vt.push_back(mk(1, 4'b0011, 1, 0, 0, FF, 1, 0, 0, 0));
        vt.push_back(mk(0, 4'b0000, 0, 0, 0, FF, 2, 0, 0, 0));

        foreach (vt[i]) begin
            t = vt[i];
            for (int r = 0; r < t.rep; r++) begin
                reset = t.rst; src_req = t.req; auto_en = t.aut;
                step = t.stp; hold = t.hld; sv[3] = t.sv3;
                @(posedge clk);
                #1;
                ev = t.e_vld ? tagged_val(t.e_raw, int'(t.e_sel)) : 32'h0;
                check($sformatf("vec%0d.%0d vld", i, r), 32'(disp_vld), 32'(t.e_vld));
                check($sformatf("vec%0d.%0d sel", i, r), 32'(disp_sel), 32'(t.e_sel));
                check($sformatf("vec%0d.%0d val", i, r), disp_val, ev);
            end
        end

        reset = 1'b1; step = 1'b0; hold = 1'b0; src_req = '0; auto_en = 1'b1;
        for (int k = 0; k < 4; k++) sv[k] = $urandom;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("rnd%0d vld", i), 32'(disp_vld), 32'(m_mode != 0));
            check($sformatf("rnd%0d sel", i), 32'(disp_sel), 32'(m_sel));
            check($sformatf("rnd%0d val", i), disp_val, m_val);
            reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 9) == 0) src_req = 4'($urandom);
            if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
            step = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 14) == 0) hold = ~hold;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 5) == 0) sv[k] = $urandom;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
